div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle sequencer for the RV32M divide group (DIV, DIVU, REM, REMU, funct3 100-111). ALU_Decoder
//  leaves these unmapped; this block covers them.
//  Sits beside the EX-stage ALU. Accepts one op, stalls the pipeline while it runs a radix-2 restoring
//  divide, then presents the result for one cycle.
// PARAMETERS
//  XLEN    32   operand/result width
//  CNT_W   6    iteration counter width; must hold XLEN
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-low
//  start       in   1      EX holds a divide op; sampled only in IDLE
//  funct3      in   3      100 DIV, 101 DIVU, 110 REM, 111 REMU
//  src_a       in   XLEN   dividend
//  src_b       in   XLEN   divisor
//  flush       in   1      kill the in-flight op (branch/jump redirect)
//  stall       out  1      freeze IF/ID/EX
//  busy        out  1      registered; high in CALC and DONE
//  valid       out  1      one-cycle result strobe
//  result      out  XLEN   quotient (DIV/DIVU) or remainder (REM/REMU)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, busy=0, valid=0, result=0, internal regs=0.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE
//   - start=1, flush=0: latch funct3, the sign flags, |src_a| and |src_b|.
//     Magnitudes are taken only for DIV/REM; DIVU/REMU use raw values.
//   - Then go to CALC, counter=XLEN.
//   - Special cases go straight to DONE instead:
//     - src_b==0: quotient all-ones; remainder = src_a.
//     - Signed overflow (DIV/REM, src_a=0x8000_0000, src_b=-1): quotient = src_a; remainder = 0.
//  CALC
//   - Each cycle: shift the {rem, quo} pair left by 1.
//   - Trial-subtract the divisor on the XLEN+1-bit remainder.
//   - If the result is non-negative, keep it and set the quotient LSB.
//   - Counter decrements; counter==1 -> DONE.
//  DONE
//   - valid=1 for exactly one cycle; result registered; next state IDLE.
//   - Sign fix: quotient negated when the signs differ (signed ops only).
//   - Remainder takes the dividend's sign.
//  Latency
//   - Normal op: valid is seen XLEN+1 cycles after the start edge (33 at default).
//   - Special case: 1 cycle.
//  stall = (state==IDLE & start & ~flush) | (state==CALC).
//   - Low in DONE, so EX advances on the valid cycle and the result is written back in step.
//  start while busy is ignored (no queueing). start in the DONE cycle is also ignored; the pipeline
//  re-issues it.
//  flush has priority over everything:
//   - In any state, the next state is IDLE and valid stays 0; result holds its last value.
//   - flush and start in the same cycle: op not accepted.
//  Reset mid-op aborts immediately; no valid is produced.
//  Non-divide funct3 with start=1 is ignored (stays IDLE, stall=0).
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   - In IDLE, an op with |src_a| < |src_b| (unsigned compare on magnitudes) goes straight to DONE.
//   - It gives quotient 0 and remainder = src_a, so latency is 1.
//  Not defined: these ops take the full XLEN+1 cycles.
//   - Results are identical either way; only the latency differs.
// TESTING
//  1. DIV 20 / -3
//     - result 0xFFFF_FFFA (-6), valid 33 cycles after start, stall high for 33 cycles.
//     - REM of the same operands: result 0x0000_0002.
//  2. DIVU 0xFFFF_FFFF / 1 -> 0xFFFF_FFFF; REMU 7 / 0xFFFF_FFFF -> 7.
//     - With DIV_EARLY_OUT_EN, the REMU finishes in 1 cycle.
//  3. DIV 5 / 0 -> 0xFFFF_FFFF; REM 5 / 0 -> 5; both valid 1 cycle after start.
//  4. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM of the same -> 0; both 1-cycle latency.
//  5. Flush and reset mid-op:
//     - Start DIV 100/7 and assert flush at cycle 10: busy drops next cycle, no valid pulse.
//     - A new DIV 100/7 afterwards returns 14 at full latency.
//     - Repeat with rst low at cycle 10: all outputs 0 immediately.
//  6. Hold start high through a whole op, then assert start together with flush in IDLE:
//     - Only the first op completes, exactly one valid pulse; the flushed start is never accepted.

Source files
------------

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU
// Optional macro DIV_EARLY_OUT_EN: ops with |dividend| < |divisor| finish in one cycle.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_valid;
    logic [XLEN-1:0]  r_result;

    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div0;
    logic             w_ovf;
    logic             w_early;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic [XLEN-1:0]  w_final;

    // funct3[2] marks the divide group; funct3[0] set means unsigned
    assign w_accept = (r_state == S_IDLE) & i_start & ~i_flush & i_funct3[2];
    assign w_signed = ~i_funct3[0];
    assign w_a_neg  = w_signed & i_src_a[XLEN-1];
    assign w_b_neg  = w_signed & i_src_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? ('0 - i_src_a) : i_src_a;
    assign w_abs_b  = w_b_neg ? ('0 - i_src_b) : i_src_b;
    assign w_div0   = (i_src_b == '0);
    assign w_ovf    = w_signed & (i_src_a == MIN_NEG) & (i_src_b == '1);

`ifdef DIV_EARLY_OUT_EN
    assign w_early  = (w_abs_a < w_abs_b);
`else
    assign w_early  = 1'b0;
`endif

    // Remainder is always below the divisor, so only the shifted value needs the extra bit
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, r_div};
    assign w_quo_fix = r_neg_q ? ('0 - r_quo) : r_quo;
    assign w_rem_fix = r_neg_r ? ('0 - r_rem) : r_rem;
    assign w_final   = r_is_rem ? w_rem_fix : w_quo_fix;

    assign o_stall  = w_accept | (r_state == S_CALC);
    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_result = r_result;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_div0 | w_ovf | w_early) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_flush) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            r_busy  <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= i_funct3[1];
                        r_cnt    <= CNT_W'(XLEN);
                        r_div    <= w_abs_b;
                        // Special cases load final values directly and skip the sign fix
                        if (w_div0) begin
                            r_quo   <= '1;
                            r_rem   <= i_src_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_ovf) begin
                            r_quo   <= i_src_a;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_early) begin
                            r_quo   <= '0;
                            r_rem   <= i_src_a;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quo   <= w_abs_a;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (!w_trial[XLEN]) begin
                        r_rem <= w_trial[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    if (!i_flush) begin
                        r_valid  <= 1'b1;
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_valid  = 0;

    typedef struct {
        logic [31:0] res;
        int          t;
    } obs_t;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    obs_t got_q[$];
    exp_t exp_q[$];

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_start  (start),
        .i_funct3 (funct3),
        .i_src_a  (src_a),
        .i_src_b  (src_b),
        .i_flush  (flush),
        .o_stall  (stall),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid <= n_valid + 1;
            got_q.push_back('{res: result, t: cyc});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            3'b111: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic [31:0] aa;
        logic [31:0] ab;
        sgn = ~f3[0];
        aa  = (sgn && a[31]) ? -a : a;
        ab  = (sgn && b[31]) ? -b : b;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (aa < ab) return 1;
`endif
        if (aa == ab && aa == 32'hFFFF_FFFF) return 33;
        return 33;
    endfunction

    task automatic score(input string tag, input int waited);
        exp_t e;
        obs_t o;
        e = exp_q.pop_front();
        if (got_q.size() == 0) begin
            check_eq({tag, "_timeout"}, 32'(waited), 32'(0));
        end else begin
            o = got_q.pop_front();
            check_eq({tag, "_result"}, o.res, e.res);
            check_eq({tag, "_latency"}, 32'(o.t - e.t0), 32'(e.lat));
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        int stalls;
        int n;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        src_a  = a;
        src_b  = b;
        exp_q.push_back('{tag: tag, res: exp_res, lat: model_lat(f3, a, b), t0: cyc + 1});
        #1;
        stalls = int'(stall);
        n = 0;
        while (got_q.size() == 0 && n < 60) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            stalls += int'(stall);
            n++;
        end
        check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(model_lat(f3, a, b)));
        score(tag, n);
    endtask

    initial begin
        int v0;
        int n;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        rst_n  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        src_a  = '0;
        src_b  = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_busy",   32'(busy),  0);
        check_eq("reset_valid",  32'(valid), 0);
        check_eq("reset_stall",  32'(stall), 0);
        check_eq("reset_result", result,     0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div_20_m3",   3'b100, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
        run_op("rem_20_m3",   3'b110, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002);
        run_op("divu_max_1",  3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_op("remu_7_max",  3'b111, 32'd7, 32'hFFFF_FFFF, 32'd7);
        run_op("div_5_0",     3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_5_0",     3'b110, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_m3_5",    3'b100, 32'hFFFF_FFFD, 32'd5, 32'h0);

        // non-divide funct3 is ignored
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b000;
        src_a  = 32'd9;
        src_b  = 32'd3;
        #1;
        check_eq("nondiv_stall", 32'(stall), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("nondiv_busy", 32'(busy), 0);

        // flush mid-op
        @(negedge clk);
        v0     = n_valid;
        start  = 1'b1;
        funct3 = 3'b100;
        src_a  = 32'd100;
        src_b  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check_eq("flush_busy_before", 32'(busy), 1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_busy_after",  32'(busy),  0);
        check_eq("flush_stall_after", 32'(stall), 0);
        repeat (40) @(negedge clk);
        #1;
        check_eq("flush_no_valid", 32'(n_valid - v0), 0);
        got_q.delete();
        run_op("div_100_7", 3'b100, 32'd100, 32'd7, 32'd14);

        // reset mid-op
        @(negedge clk);
        v0     = n_valid;
        start  = 1'b1;
        funct3 = 3'b100;
        src_a  = 32'd100;
        src_b  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy",   32'(busy),  0);
        check_eq("midrst_valid",  32'(valid), 0);
        check_eq("midrst_stall",  32'(stall), 0);
        check_eq("midrst_result", result,     0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check_eq("midrst_no_valid", 32'(n_valid - v0), 0);
        got_q.delete();

        // start held through an op, then start together with flush in IDLE
        @(negedge clk);
        v0     = n_valid;
        start  = 1'b1;
        funct3 = 3'b100;
        src_a  = 32'd20;
        src_b  = 32'hFFFF_FFFD;
        exp_q.push_back('{tag: "hold_start", res: 32'hFFFF_FFFA, lat: 33, t0: cyc + 1});
        n = 0;
        while (got_q.size() == 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        flush = 1'b1;
        #1;
        check_eq("hold_flush_stall", 32'(stall), 0);
        score("hold_start", n);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check_eq("hold_flush_busy", 32'(busy), 0);
        repeat (40) @(negedge clk);
        #1;
        check_eq("hold_one_valid", 32'(n_valid - v0), 1);
        got_q.delete();

        for (int i = 0; i < 16; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                default: begin
                    b = $urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
                end
            endcase
            run_op($sformatf("rnd%0d", i), f3, a, b, model_res(f3, a, b));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
